pipe_cla_addsub: RTL and testbench
==================================

Name: pipe_cla_addsub

Overview:
- Parametrised, pipelined WIDTH-bit adder/subtractor for the execute stage.
- Built from SLICE_W-bit carry-lookahead slices, split across STAGES register stages; carry crosses stage boundaries through registers.
- Valid/ready handshake on input and output; full throughput of one operation per cycle.
- Supports ADD, SUB, ADC and SBC, and produces carry, signed-overflow and zero flags.

Parameters:
- WIDTH, 32, operand/result width. Must be divisible by STAGES*SLICE_W.
- SLICE_W, 4, bits per lookahead slice.
- STAGES, 2, number of register stages. CHUNK = WIDTH/STAGES bits are resolved per stage. Latency = STAGES cycles.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- in_valid_i  in  1  operation present.
- in_ready_o  out  1  block can accept this cycle.
- op_i  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBC.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- cin_i  in  1  carry-in; used by ADC/SBC only.
- out_valid_o  out  1  result present.
- out_ready_i  in  1  downstream accepts.
- sum_o  out  WIDTH  result.
- cout_o  out  1  carry out of the MSB (1 = no borrow for SUB/SBC).
- ovf_o  out  1  signed overflow.
- zero_o  out  1  sum_o == 0.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Operand prep (combinational, at input):
  - B' = b_i for ADD/ADC; B' = ~b_i for SUB/SBC.
  - c0 = 0 (ADD), 1 (SUB), cin_i (ADC/SBC).
- Stage k (k = 0..STAGES-1):
  - Adds bits [k*CHUNK +: CHUNK] of A and B' with the carry registered from stage k-1 (c0 for stage 0).
  - Uses CHUNK/SLICE_W lookahead slices. Group carry is computed from slice G/P.
  - Registers: valid bit, lower sum bits produced so far, unconsumed upper A/B' bits, carry out, and the A/B' MSBs needed for the flags.
- Flags (from the final stage):
  - cout_o = carry out of the MSB.
  - ovf_o = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]).
  - zero_o = ~|sum.
- Handshake:
  - Input accepted when in_valid_i && in_ready_o.
  - Output consumed when out_valid_o && out_ready_i.
  - adv[STAGES-1] = ~v[STAGES-1] | out_ready_i.
  - adv[k] = ~v[k] | adv[k+1].
  - in_ready_o = adv[0]; it is combinational from out_ready_i.
  - A stage with adv=0 holds its contents unchanged. A stage with adv=1 loads the upstream stage's content, or invalid if the upstream has no valid data.
- Latency and throughput:
  - An accepted op appears at out_valid_o exactly STAGES cycles later when out_ready_i is held high.
  - Back-to-back ops sustain 1/cycle. Results are returned in strict order.
- Data stability: while out_valid_o=1 and out_ready_i=0, sum_o and all flags are stable.
- Reset:
  - When rst_i=1 at a clock edge, all valid bits and data registers clear to 0.
  - Next cycle: out_valid_o=0, sum_o=0, cout_o=0, ovf_o=0, zero_o=0, in_ready_o=1.
  - In-flight ops are dropped and never emerge. Input is ignored during the reset cycle.
- Full pipeline: with all STAGES valid and out_ready_i=0, in_ready_o=0 and no op is lost.
- Simultaneous accept and consume: the pipeline shifts with no bubble.
- Wrap-around: sums are modulo 2^WIDTH. The carry is reported only via cout_o.
- Zero flag on invalid output: zero_o is 0 when out_valid_o=0 (gated by valid).

Decomposition:
- Package alu_pkg: op encodings (OP_ADD, OP_SUB, OP_ADC, OP_SBC) and the op_t 2-bit typedef.
- Sub-module cla_slice: combinational, parameter SLICE_W.
  - Ports: a, b, cin, sum, g, p, cout.
  - Instantiated CHUNK/SLICE_W times per stage via generate.
- Top level owns the prep logic, stage registers, the handshake chain and the flags.

Test Plan:
- ADD a=0xFFFFFFFF b=0x00000001, out_ready_i=1 -> 2 cycles later sum=0x00000000, cout=1, ovf=0, zero=1.
- SUB a=0x80000000 b=0x00000001 -> sum=0x7FFFFFFF, cout=1, ovf=1, zero=0.
- ADC a=0x7FFFFFFF b=0 cin_i=1 -> sum=0x80000000, cout=0, ovf=1. SBC a=5 b=5 cin_i=0 -> sum=0xFFFFFFFF, cout=0.
- Streaming: 8 random ops on consecutive cycles, out_ready_i=1 -> 8 results on consecutive cycles starting at cycle 2, in order, matching the reference model.
- Backpressure: out_ready_i=0 for 6 cycles while issuing continuously -> in_ready_o falls after 2 accepts, outputs are stable; on release, results drain 1/cycle with no loss or duplication.
- Reset mid-flight: rst_i high for 1 cycle with 2 ops in flight -> next cycle out_valid_o=0 and all outputs 0; neither op ever appears. Repeat the suite with STAGES=1 (latency 1) and STAGES=4 (latency 4).

Source files
------------

// File: rtl/alu_pkg.sv
// Operation encodings shared by the execute-stage adder/subtractor.
// Latency: none (type and helper definitions only).
// Backpressure: not applicable.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_t;

  // SUB and SBC add the one's complement of B.
  function automatic logic op_inverts_b(input op_t op);
    return (op == OP_SUB) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/cla_slice.sv
// SLICE_W-bit carry-lookahead slice: sum plus group generate/propagate.
// Latency: purely combinational.
// Backpressure: not applicable.
module cla_slice #(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               g,
  output logic               p,
  output logic               cout
);

  logic [SLICE_W-1:0] w_gen;
  logic [SLICE_W-1:0] w_prop;
  logic [SLICE_W-1:0] w_carry;

  assign w_gen  = a & b;
  assign w_prop = a ^ b;

  // Group G/P depend only on the operands, never on cin, so the
  // chunk-level lookahead above can use them without a loop.
  always_comb begin
    g = 1'b0;
    for (int i = 0; i < SLICE_W; i++) begin
      g = w_gen[i] | (w_prop[i] & g);
    end
    p = &w_prop;
  end

  // Per-bit carries inside the slice, then the sum and slice carry-out.
  always_comb begin
    w_carry    = '0;
    w_carry[0] = cin;
    for (int i = 1; i < SLICE_W; i++) begin
      w_carry[i] = w_gen[i-1] | (w_prop[i-1] & w_carry[i-1]);
    end
    sum  = w_prop ^ w_carry;
    cout = g | (p & cin);
  end

endmodule

// File: rtl/pipe_cla_addsub.sv
// Pipelined WIDTH-bit ADD/SUB/ADC/SBC built from carry-lookahead slices.
// Latency: STAGES cycles from accept to out_valid_o; one op per cycle.
// Backpressure: stalled stages hold; in_ready_o falls only when every stage is full and out_ready_i=0.
module pipe_cla_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 4,
  parameter int STAGES  = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int NSL   = CHUNK / SLICE_W;
  localparam int LAST  = STAGES - 1;

  op_t               w_op;
  logic [WIDTH-1:0]  w_b_prep;
  logic              w_c0;
  logic [STAGES-1:0] w_adv;

  // Stage k holds the full A/B' (upper part still to be added, MSBs for
  // the flags), the sum bits resolved so far and the carry into stage k+1.
  logic              r_vld [STAGES];
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic              r_c   [STAGES];

  // Operand prep: invert B for subtracts and select the initial carry.
  always_comb begin
    w_op     = op_t'(op_i);
    w_b_prep = op_inverts_b(w_op) ? ~b_i : b_i;
    w_c0     = 1'b0;
    case (w_op)
      OP_ADD:  w_c0 = 1'b0;
      OP_SUB:  w_c0 = 1'b1;
      OP_ADC:  w_c0 = cin_i;
      OP_SBC:  w_c0 = cin_i;
      default: w_c0 = 1'b0;
    endcase
  end

  // Advance chain: a stage may load when it is empty or its successor moves.
  always_comb begin
    w_adv       = '0;
    w_adv[LAST] = ~r_vld[LAST] | out_ready_i;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_adv[k] = ~r_vld[k] | w_adv[k+1];
    end
  end

  assign in_ready_o = w_adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] w_a_src;
    logic [WIDTH-1:0] w_b_src;
    logic [WIDTH-1:0] w_sum_src;
    logic             w_c_src;
    logic             w_v_src;
    logic [CHUNK-1:0] w_chunk_sum;
    logic [NSL-1:0]   w_g;
    logic [NSL-1:0]   w_p;
    logic [NSL:0]     w_gc;
    logic [WIDTH-1:0] w_sum_nxt;
    // Slice-local carry-outs; the chunk carries are resolved from G/P.
    logic [NSL-1:0]   w_slice_cout_unused;

    if (k == 0) begin : g_first
      assign w_a_src   = a_i;
      assign w_b_src   = w_b_prep;
      assign w_sum_src = '0;
      assign w_c_src   = w_c0;
      assign w_v_src   = in_valid_i;
    end else begin : g_next
      assign w_a_src   = r_a[k-1];
      assign w_b_src   = r_b[k-1];
      assign w_sum_src = r_sum[k-1];
      assign w_c_src   = r_c[k-1];
      assign w_v_src   = r_vld[k-1];
    end

    for (genvar j = 0; j < NSL; j++) begin : g_slice
      cla_slice #(.SLICE_W(SLICE_W)) u_slice (
        .a    (w_a_src[k*CHUNK + j*SLICE_W +: SLICE_W]),
        .b    (w_b_src[k*CHUNK + j*SLICE_W +: SLICE_W]),
        .cin  (w_gc[j]),
        .sum  (w_chunk_sum[j*SLICE_W +: SLICE_W]),
        .g    (w_g[j]),
        .p    (w_p[j]),
        .cout (w_slice_cout_unused[j])
      );
    end

    // Chunk-level lookahead: carry into each slice from the slice G/P.
    always_comb begin
      w_gc    = '0;
      w_gc[0] = w_c_src;
      for (int j = 0; j < NSL; j++) begin
        w_gc[j+1] = w_g[j] | (w_p[j] & w_gc[j]);
      end
    end

    // Splice this stage's chunk into the running sum.
    always_comb begin
      w_sum_nxt = w_sum_src;
      w_sum_nxt[k*CHUNK +: CHUNK] = w_chunk_sum;
    end

    // Stage register: hold on stall, take upstream on advance; data only
    // moves with a valid op, an empty upstream just clears the valid bit.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_vld[k] <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
        r_c[k]   <= 1'b0;
      end else if (w_adv[k]) begin
        r_vld[k] <= w_v_src;
        if (w_v_src) begin
          r_a[k]   <= w_a_src;
          r_b[k]   <= w_b_src;
          r_sum[k] <= w_sum_nxt;
          r_c[k]   <= w_gc[NSL];
        end
      end
    end
  end

  assign out_valid_o = r_vld[LAST];
  assign sum_o       = r_sum[LAST];
  assign cout_o      = r_c[LAST];
  assign ovf_o       = (r_a[LAST][WIDTH-1] == r_b[LAST][WIDTH-1]) &&
                       (r_sum[LAST][WIDTH-1] != r_a[LAST][WIDTH-1]);
  assign zero_o      = r_vld[LAST] & ~|r_sum[LAST];

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Self-checking bench: three instances (STAGES = 1, 2, 4) share one stimulus stream.
// Latency: each instance is checked against its own STAGES-cycle expectation.
// Backpressure: random and directed out_ready stalls, checked against an in-flight model.
module tb_pipe_cla_addsub;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    int          acc;
  } ent_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        out_ready = 1'b0;

  logic        d_in_ready  [3];
  logic        d_out_valid [3];
  logic [31:0] d_sum       [3];
  logic        d_cout      [3];
  logic        d_ovf       [3];
  logic        d_zero      [3];

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   pend [3];
  logic check_en = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Reference from plain integer arithmetic: {cout, ovf, zero, sum}.
  function automatic logic [34:0] ref_op(input logic [1:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input logic c);
    longint ux, uy, ures, sx, sy, sres, ci;
    logic [31:0] s;
    logic co, ov;
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ci = c ? 64'sd1 : 64'sd0;
    case (o)
      2'b00:   begin ures = ux + uy;              sres = sx + sy;              end
      2'b01:   begin ures = ux - uy;              sres = sx - sy;              end
      2'b10:   begin ures = ux + uy + ci;         sres = sx + sy + ci;         end
      default: begin ures = ux - uy - (1 - ci);   sres = sx - sy - (1 - ci);   end
    endcase
    s  = ures[31:0];
    // For subtracts the carry means "no borrow", i.e. the true difference is >= 0.
    co = o[0] ? (ures >= 0) : (ures > 64'sd4294967295);
    ov = (sres > SMAX) || (sres < SMIN);
    return {co, ov, (s == 32'h0), s};
  endfunction

  for (genvar d = 0; d < 3; d++) begin : g_dut
    localparam int S = 1 << d;
    ent_t        q[$];
    ent_t        e;
    logic        post_rst = 1'b0;
    logic        exp_rdy;
    logic        exp_vld;
    logic [34:0] r;

    pipe_cla_addsub #(.WIDTH(32), .SLICE_W(4), .STAGES(S)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (d_in_ready[d]),
      .op_i        (op),
      .a_i         (a),
      .b_i         (b),
      .cin_i       (cin),
      .out_valid_o (d_out_valid[d]),
      .out_ready_i (out_ready),
      .sum_o       (d_sum[d]),
      .cout_o      (d_cout[d]),
      .ovf_o       (d_ovf[d]),
      .zero_o      (d_zero[d])
    );

    // Compare every cycle at the falling edge, then apply the handshakes
    // that the coming rising edge will perform.
    always @(negedge clk) begin
      if (check_en) begin
        exp_rdy = out_ready || (q.size() < S);
        // The oldest op never waits behind anything, so it is visible S cycles after acceptance.
        exp_vld = (q.size() > 0) && ((cyc - q[0].acc) >= S);
        chk($sformatf("s%0d_in_ready", S), d_in_ready[d], exp_rdy);
        chk($sformatf("s%0d_out_valid", S), d_out_valid[d], exp_vld);
        if (exp_vld && d_out_valid[d]) begin
          r = ref_op(q[0].op, q[0].a, q[0].b, q[0].cin);
          chk($sformatf("s%0d_sum", S), d_sum[d], r[31:0]);
          chk($sformatf("s%0d_cout", S), d_cout[d], r[34]);
          chk($sformatf("s%0d_ovf", S), d_ovf[d], r[33]);
          chk($sformatf("s%0d_zero", S), d_zero[d], r[32]);
        end
        if (!exp_vld) chk($sformatf("s%0d_zero_gated", S), d_zero[d], 1'b0);
        if (post_rst) begin
          chk($sformatf("s%0d_rst_sum", S), d_sum[d], 32'h0);
          chk($sformatf("s%0d_rst_flags", S), {d_cout[d], d_ovf[d], d_zero[d]}, 3'b000);
        end
        if (rst) begin
          q.delete();
          post_rst = 1'b1;
        end else begin
          post_rst = 1'b0;
          if (exp_vld && out_ready) void'(q.pop_front());
          if (in_valid && exp_rdy) begin
            e.op = op; e.a = a; e.b = b; e.cin = cin; e.acc = cyc;
            q.push_back(e);
          end
        end
        pend[d] = q.size();
      end
    end
  end

  task automatic drive(input logic r_in, input logic v, input logic [1:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic c, input logic rdy);
    rst = r_in; in_valid = v; op = o; a = x; b = y; cin = c; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  logic [1:0]  t_op  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [31:0] t_a   [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0005};
  logic [31:0] t_b   [4] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0005};
  logic        t_cin [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] t_sum [4] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
  logic [2:0]  t_flg [4] = '{3'b101, 3'b110, 3'b010, 3'b000};  // {cout, ovf, zero}

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;
    drive(1, 0, 2'b00, 0, 0, 0, 1);

    // Pin the reference model to hand-computed results.
    for (int i = 0; i < 4; i++)
      chk($sformatf("model_%0d", i), ref_op(t_op[i], t_a[i], t_b[i], t_cin[i]),
          {t_flg[i], t_sum[i]});

    // Directed ops: the STAGES=2 instance shows each result two cycles later.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, t_op[i], t_a[i], t_b[i], t_cin[i], 1);
      drive(0, 0, 2'b00, 0, 0, 0, 1);
      chk($sformatf("dir%0d_valid", i), d_out_valid[1], 1'b1);
      chk($sformatf("dir%0d_sum", i), d_sum[1], t_sum[i]);
      chk($sformatf("dir%0d_flags", i), {d_cout[1], d_ovf[1], d_zero[1]}, t_flg[i]);
    end

    // Streaming: eight back-to-back ops with the sink always ready.
    for (int i = 0; i < 8; i++)
      drive(0, 1, 2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)), 1);
    repeat (6) drive(0, 0, 2'b00, 0, 0, 0, 1);

    // Backpressure: sink stalled for six cycles while the source keeps issuing.
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)), 0);
      if (i == 1) begin
        chk("bp_s1_ready", d_in_ready[0], 1'b0);
        chk("bp_s2_ready", d_in_ready[1], 1'b0);
        chk("bp_s4_ready", d_in_ready[2], 1'b1);
      end
    end
    chk("bp_s4_full", d_in_ready[2], 1'b0);
    repeat (8) drive(0, 0, 2'b00, 0, 0, 0, 1);

    // Reset with two ops in flight.
    drive(0, 1, 2'b00, 32'h1234_5678, 32'h1111_1111, 0, 1);
    drive(0, 1, 2'b01, 32'h0000_0010, 32'h0000_0001, 0, 1);
    drive(1, 1, 2'b00, 32'hDEAD_BEEF, 32'h1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mid_rst_valid%0d", i), d_out_valid[i], 1'b0);
      chk($sformatf("mid_rst_ready%0d", i), d_in_ready[i], 1'b1);
    end
    repeat (6) drive(0, 0, 2'b00, 0, 0, 0, 1);

    // Random traffic with random stalls and occasional resets.
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0));

    repeat (8) drive(0, 0, 2'b00, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("drain%0d", i), pend[i], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
